// File: rtl/fi_recovery_sequencer_if.sv
// fi_recovery_sequencer_if: triggers, core flush/drain control, arch-register copy
// port, memory-copy handshake and status of the fault-injection recovery sequencer.
interface fi_recovery_sequencer_if #(
    parameter int SIZE_RMT_LOG = 6,
    parameter int SIZE_DATA    = 64,
    parameter int SIZE_PC      = 64
);
    logic                    fault_prop_i;
    logic                    braindead_i;
    logic                    bad_syscall_i;
    logic [SIZE_PC-1:0]      arch_pc_i;
    logic                    exception_i;
    logic                    stq_empty_i;
    logic                    flush_req_o;
    logic                    reg_rd_req_o;
    logic [SIZE_RMT_LOG-1:0] reg_rd_idx_o;
    logic                    reg_rd_valid_i;
    logic [SIZE_DATA-1:0]    reg_rd_data_i;
    logic                    rf_wr_en_o;
    logic [SIZE_RMT_LOG-1:0] rf_wr_idx_o;
    logic [SIZE_DATA-1:0]    rf_wr_data_o;
    logic                    mem_copy_req_o;
    logic                    mem_copy_done_i;
    logic                    resume_valid_o;
    logic [SIZE_PC-1:0]      resume_pc_o;
    logic [1:0]              cause_o;
    logic                    busy_o;
    logic                    double_fault_o;
    logic                    drain_timeout_o;
    logic [15:0]             recovery_cnt_o;

    modport master (
        input  fault_prop_i,
        input  braindead_i,
        input  bad_syscall_i,
        input  arch_pc_i,
        input  exception_i,
        input  stq_empty_i,
        output flush_req_o,
        output reg_rd_req_o,
        output reg_rd_idx_o,
        input  reg_rd_valid_i,
        input  reg_rd_data_i,
        output rf_wr_en_o,
        output rf_wr_idx_o,
        output rf_wr_data_o,
        output mem_copy_req_o,
        input  mem_copy_done_i,
        output resume_valid_o,
        output resume_pc_o,
        output cause_o,
        output busy_o,
        output double_fault_o,
        output drain_timeout_o,
        output recovery_cnt_o
    );

    modport slave (
        output fault_prop_i,
        output braindead_i,
        output bad_syscall_i,
        output arch_pc_i,
        output exception_i,
        output stq_empty_i,
        input  flush_req_o,
        input  reg_rd_req_o,
        input  reg_rd_idx_o,
        output reg_rd_valid_i,
        output reg_rd_data_i,
        input  rf_wr_en_o,
        input  rf_wr_idx_o,
        input  rf_wr_data_o,
        input  mem_copy_req_o,
        output mem_copy_done_i,
        input  resume_valid_o,
        input  resume_pc_o,
        input  cause_o,
        input  busy_o,
        input  double_fault_o,
        input  drain_timeout_o,
        input  recovery_cnt_o
    );
endinterface

// File: rtl/fi_recovery_sequencer.sv
// fi_recovery_sequencer: flush -> drain -> arch-reg reload -> mem copy -> resume.
// Optional drain watchdog enabled by defining FI_RECOVERY_TIMEOUT_EN.
module fi_recovery_sequencer #(
    parameter int NUM_LOG_REGS  = 34,
    parameter int SIZE_RMT_LOG  = 6,
    parameter int SIZE_DATA     = 64,
    parameter int SIZE_PC       = 64,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input logic                     clk,
    input logic                     reset_n,
    fi_recovery_sequencer_if.master bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] FLUSH    = 3'd1;
    localparam logic [2:0] DRAIN    = 3'd2;
    localparam logic [2:0] REG_COPY = 3'd3;
    localparam logic [2:0] MEM_COPY = 3'd4;
    localparam logic [2:0] RESUME   = 3'd5;

    localparam logic [SIZE_RMT_LOG-1:0] LAST_IDX =
        SIZE_RMT_LOG'(NUM_LOG_REGS - 1);

    if (NUM_LOG_REGS < 1 || NUM_LOG_REGS > (1 << SIZE_RMT_LOG) ||
        DRAIN_TIMEOUT < 1) begin : g_bad_cfg
        $error("fi_recovery_sequencer: bad parameter set");
    end

    logic [2:0]              state;
    logic [1:0]              cause;
    logic [SIZE_PC-1:0]      resume_pc;
    logic                    rd_req;
    logic [SIZE_RMT_LOG-1:0] rd_idx;
    logic                    wr_en;
    logic [SIZE_RMT_LOG-1:0] wr_idx;
    logic [SIZE_DATA-1:0]    wr_data;
    logic                    dbl;
    logic [15:0]             rec_cnt;
    logic                    trig;
    logic [1:0]              trig_cause;
    logic                    drain_abort;

    assign trig = bus.fault_prop_i | bus.braindead_i | bus.bad_syscall_i;

    always_comb begin
        trig_cause = 2'd0;
        if (bus.braindead_i)
            trig_cause = 2'd3;
        else if (bus.bad_syscall_i)
            trig_cause = 2'd2;
        else if (bus.fault_prop_i)
            trig_cause = 2'd1;
    end

`ifdef FI_RECOVERY_TIMEOUT_EN
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

    logic [TW-1:0] drain_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            drain_cnt <= '0;
        else if (state == DRAIN)
            drain_cnt <= drain_cnt + 1'b1;
        else
            drain_cnt <= '0;
    end

    // Fires in the DRAIN_TIMEOUT-th drain cycle if the store queue is still busy.
    assign drain_abort = (state == DRAIN) && !bus.stq_empty_i &&
                         (drain_cnt == TW'(DRAIN_TIMEOUT - 1));
`else
    assign drain_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cause     <= 2'd0;
            resume_pc <= '0;
            rd_req    <= 1'b0;
            rd_idx    <= '0;
            wr_en     <= 1'b0;
            wr_idx    <= '0;
            wr_data   <= '0;
            dbl       <= 1'b0;
            rec_cnt   <= '0;
        end else begin
            wr_en <= 1'b0;
            dbl   <= trig && (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (trig) begin
                        resume_pc <= bus.arch_pc_i;
                        cause     <= trig_cause;
                        state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (bus.exception_i)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (bus.stq_empty_i) begin
                        state  <= REG_COPY;
                        rd_req <= 1'b1;
                        rd_idx <= '0;
                    end else if (drain_abort) begin
                        state <= IDLE;
                        cause <= 2'd0;
                    end
                end
                REG_COPY: begin
                    // Request stays up across the write cycle with the next index.
                    if (rd_req && bus.reg_rd_valid_i) begin
                        wr_en   <= 1'b1;
                        wr_idx  <= rd_idx;
                        wr_data <= bus.reg_rd_data_i;
                        if (rd_idx == LAST_IDX) begin
                            rd_req <= 1'b0;
                            rd_idx <= '0;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                    if (wr_en && (wr_idx == LAST_IDX))
                        state <= MEM_COPY;
                end
                MEM_COPY: begin
                    if (bus.mem_copy_done_i)
                        state <= RESUME;
                end
                RESUME: begin
                    if (rec_cnt != 16'hFFFF)
                        rec_cnt <= rec_cnt + 16'd1;
                    cause <= 2'd0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.flush_req_o     = (state == FLUSH);
    assign bus.reg_rd_req_o    = rd_req;
    assign bus.reg_rd_idx_o    = rd_idx;
    assign bus.rf_wr_en_o      = wr_en;
    assign bus.rf_wr_idx_o     = wr_idx;
    assign bus.rf_wr_data_o    = wr_data;
    assign bus.mem_copy_req_o  = (state == MEM_COPY);
    assign bus.resume_valid_o  = (state == RESUME);
    assign bus.resume_pc_o     = resume_pc;
    assign bus.cause_o         = cause;
    assign bus.busy_o          = (state != IDLE);
    assign bus.double_fault_o  = dbl;
    assign bus.drain_timeout_o = drain_abort;
    assign bus.recovery_cnt_o  = rec_cnt;
endmodule

// File: tb/tb_fi_recovery_sequencer.sv
// Directed bench for fi_recovery_sequencer; environment responders run inside tick().
// Build with FI_RECOVERY_TIMEOUT_EN to add the drain-watchdog case.
module tb_fi_recovery_sequencer;
    localparam int NREG = 34;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    fi_recovery_sequencer_if #(
        .SIZE_RMT_LOG(6), .SIZE_DATA(64), .SIZE_PC(64)
    ) bus ();

    fi_recovery_sequencer #(
        .NUM_LOG_REGS(NREG), .SIZE_RMT_LOG(6), .SIZE_DATA(64),
        .SIZE_PC(64), .DRAIN_TIMEOUT(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    int exp_idx, nwr, nres, ndf;
    int fl_cnt, mc_cnt, dly, max_dly, inj_idx, dc;
    bit inj_on;
    logic [63:0] exp_pc;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.fault_prop_i    = 1'b0;
        bus.braindead_i     = 1'b0;
        bus.bad_syscall_i   = 1'b0;
        bus.arch_pc_i       = '0;
        bus.exception_i     = 1'b0;
        bus.reg_rd_valid_i  = 1'b0;
        bus.reg_rd_data_i   = '0;
        bus.mem_copy_done_i = 1'b0;
        fl_cnt = 0;
        mc_cnt = 0;
        inj_on = 1'b0;
    endtask

    task automatic start();
        exp_idx = 0;
        nwr     = 0;
        nres    = 0;
        ndf     = 0;
        dly     = int'($urandom_range(max_dly, 0));
    endtask

    // One clock: observe outputs #1 after the edge, then drive the responders.
    task automatic tick();
        logic [63:0] e;
        @(posedge clk);
        #1;
        if (inj_on) begin
            bus.bad_syscall_i = 1'b0;
            inj_on = 1'b0;
        end
        if (bus.rf_wr_en_o) begin
            e = 64'(exp_idx);
            check("wr_idx", 64'(bus.rf_wr_idx_o), e);
            check("wr_data", bus.rf_wr_data_o, e * 64'h11);
            if (exp_idx == inj_idx) begin
                bus.bad_syscall_i = 1'b1;
                inj_on = 1'b1;
            end
            exp_idx++;
            nwr++;
        end
        if (bus.resume_valid_o) begin
            nres++;
            check("resume_pc", bus.resume_pc_o, exp_pc);
        end
        if (bus.double_fault_o)
            ndf++;
        if (bus.flush_req_o) begin
            fl_cnt++;
            bus.exception_i = (fl_cnt == 3);
        end else begin
            fl_cnt = 0;
            bus.exception_i = 1'b0;
        end
        if (bus.mem_copy_req_o) begin
            mc_cnt++;
            bus.mem_copy_done_i = (mc_cnt == 5);
        end else begin
            mc_cnt = 0;
            bus.mem_copy_done_i = 1'b0;
        end
        if (bus.reg_rd_valid_i) begin
            bus.reg_rd_valid_i = 1'b0;
            dly = int'($urandom_range(max_dly, 0));
        end
        if (bus.reg_rd_req_o) begin
            if (dly == 0) begin
                bus.reg_rd_valid_i = 1'b1;
                bus.reg_rd_data_i  = 64'(bus.reg_rd_idx_o) * 64'h11;
            end else begin
                dly--;
            end
        end
    endtask

    task automatic trigger(bit fp, bit bd, bit sc, logic [63:0] pc);
        bus.fault_prop_i  = fp;
        bus.braindead_i   = bd;
        bus.bad_syscall_i = sc;
        bus.arch_pc_i     = pc;
        exp_pc            = pc;
        tick();
        bus.fault_prop_i  = 1'b0;
        bus.braindead_i   = 1'b0;
        if (!inj_on)
            bus.bad_syscall_i = 1'b0;
    endtask

    task automatic run_to_idle(string tag, int budget);
        int n = 0;
        while (bus.busy_o && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, 64'(bus.busy_o), 64'd0);
    endtask

    task automatic check_zero(string p);
        check({p, "_busy"}, 64'(bus.busy_o), 64'd0);
        check({p, "_flush"}, 64'(bus.flush_req_o), 64'd0);
        check({p, "_rdreq"}, 64'(bus.reg_rd_req_o), 64'd0);
        check({p, "_rdidx"}, 64'(bus.reg_rd_idx_o), 64'd0);
        check({p, "_wren"}, 64'(bus.rf_wr_en_o), 64'd0);
        check({p, "_wridx"}, 64'(bus.rf_wr_idx_o), 64'd0);
        check({p, "_wrdata"}, bus.rf_wr_data_o, 64'd0);
        check({p, "_memreq"}, 64'(bus.mem_copy_req_o), 64'd0);
        check({p, "_resv"}, 64'(bus.resume_valid_o), 64'd0);
        check({p, "_respc"}, bus.resume_pc_o, 64'd0);
        check({p, "_cause"}, 64'(bus.cause_o), 64'd0);
        check({p, "_dbl"}, 64'(bus.double_fault_o), 64'd0);
        check({p, "_dto"}, 64'(bus.drain_timeout_o), 64'd0);
        check({p, "_cnt"}, 64'(bus.recovery_cnt_o), 64'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        max_dly = 0;
        inj_idx = -1;
        bus.stq_empty_i = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        reset_n = 1'b1;

        // Single fault_prop recovery with zero-latency register port.
        start();
        trigger(1'b1, 1'b0, 1'b0, 64'h400100);
        check("t1_busy", 64'(bus.busy_o), 64'd1);
        check("t1_cause", 64'(bus.cause_o), 64'd1);
        check("t1_flush", 64'(bus.flush_req_o), 64'd1);
        run_to_idle("t1", 400);
        check("t1_nwr", 64'(nwr), 64'(NREG));
        check("t1_nres", 64'(nres), 64'd1);
        check("t1_cnt", 64'(bus.recovery_cnt_o), 64'd1);
        check("t1_cause_clr", 64'(bus.cause_o), 64'd0);
        check("t1_dbl", 64'(ndf), 64'd0);
        check("t1_rdidx", 64'(bus.reg_rd_idx_o), 64'd0);

        // Simultaneous braindead + fault_prop is one recovery, braindead cause.
        do_reset();
        start();
        trigger(1'b1, 1'b1, 1'b0, 64'h8000);
        check("t2_cause", 64'(bus.cause_o), 64'd3);
        run_to_idle("t2", 400);
        check("t2_nres", 64'(nres), 64'd1);
        check("t2_cnt", 64'(bus.recovery_cnt_o), 64'd1);
        check("t2_dbl", 64'(ndf), 64'd0);

        // Syscall during REG_COPY only raises double_fault.
        start();
        inj_idx = 5;
        trigger(1'b1, 1'b0, 1'b0, 64'h1234);
        run_to_idle("t3", 400);
        inj_idx = -1;
        check("t3_dbl", 64'(ndf), 64'd1);
        check("t3_nwr", 64'(nwr), 64'(NREG));
        check("t3_nres", 64'(nres), 64'd1);
        check("t3_cnt", 64'(bus.recovery_cnt_o), 64'd2);

        // Register port answers after 0..4 cycles.
        max_dly = 4;
        start();
        trigger(1'b0, 1'b0, 1'b1, 64'hABC0);
        check("t4_cause", 64'(bus.cause_o), 64'd2);
        run_to_idle("t4", 800);
        max_dly = 0;
        check("t4_nwr", 64'(nwr), 64'(NREG));
        check("t4_cnt", 64'(bus.recovery_cnt_o), 64'd3);

        // Store queue busy holds DRAIN.
        start();
        bus.stq_empty_i = 1'b0;
        trigger(1'b1, 1'b0, 1'b0, 64'h2000);
        repeat (8) tick();
        check("t5_busy", 64'(bus.busy_o), 64'd1);
        check("t5_flush", 64'(bus.flush_req_o), 64'd0);
        check("t5_rdreq", 64'(bus.reg_rd_req_o), 64'd0);
        check("t5_dto", 64'(bus.drain_timeout_o), 64'd0);
        bus.stq_empty_i = 1'b1;
        run_to_idle("t5", 400);
        check("t5_nwr", 64'(nwr), 64'(NREG));
        check("t5_cnt", 64'(bus.recovery_cnt_o), 64'd4);

        // Reset after idx 10 is written, then a clean restart from idx 0.
        start();
        trigger(1'b1, 1'b0, 1'b0, 64'h3000);
        n = 0;
        while (nwr < 11 && n < 300) begin
            tick();
            n++;
        end
        check("t6_reach", 64'(nwr), 64'd11);
        reset_n = 1'b0;
        clear_inputs();
        #1;
        check_zero("t6");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        start();
        trigger(1'b1, 1'b0, 1'b0, 64'h3100);
        run_to_idle("t6b", 400);
        check("t6_nwr", 64'(nwr), 64'(NREG));
        check("t6_cnt", 64'(bus.recovery_cnt_o), 64'd1);

`ifdef FI_RECOVERY_TIMEOUT_EN
        // Watchdog: stuck store queue aborts after 16 DRAIN cycles.
        do_reset();
        start();
        bus.stq_empty_i = 1'b0;
        trigger(1'b1, 1'b0, 1'b0, 64'h5000);
        dc = 0;
        n = 0;
        while (!bus.drain_timeout_o && n < 100) begin
            tick();
            if (bus.busy_o && !bus.flush_req_o)
                dc++;
            n++;
        end
        check("t7_dto", 64'(bus.drain_timeout_o), 64'd1);
        check("t7_dc", 64'(dc), 64'd16);
        tick();
        check("t7_busy", 64'(bus.busy_o), 64'd0);
        check("t7_dto_pulse", 64'(bus.drain_timeout_o), 64'd0);
        check("t7_cnt", 64'(bus.recovery_cnt_o), 64'd0);
        check("t7_cause", 64'(bus.cause_o), 64'd0);
        check("t7_nres", 64'(nres), 64'd0);
        bus.stq_empty_i = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
